// File: rtl/level_sequencer.sv
// Level controller for the two-hero maze: goal detection, per-level frame timer,
// multi-cycle hero reset on level transitions and a terminal win state.
module level_sequencer #(
  parameter int LEVELS      = 8,
  parameter int LVL_W       = 4,
  parameter int SCORE_W     = 24,
  parameter int POS_W       = 12,
  parameter int GOAL_X      = 482,
  parameter int GOAL_Y      = 108,
  parameter int SCORE_STEP  = 1000,
  parameter int CLEAR_HOLD  = 16,
  parameter int TIME_FRAMES = 3600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic [SCORE_W-1:0]   score,
  input  logic [2*POS_W-1:0]   hero_x_pos,
  input  logic [2*POS_W-1:0]   hero_y_pos,
  output logic [LVL_W-1:0]     level,
  output logic [SCORE_W-1:0]   score_req,
  output logic [11:0]          time_left,
  output logic                 hero_rst,
  output logic                 level_clear,
  output logic                 timeout,
  output logic                 game_won,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2,
    WON   = 2'd3
  } state_t;

  localparam int unsigned       HOLD_W    = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
  localparam int unsigned       SUM_W     = SCORE_W + 1;
  localparam logic [11:0]       TIME_INIT = 12'(TIME_FRAMES);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CLEAR_HOLD - 1);
  localparam logic [SUM_W-1:0]  STEP_EXT  = SUM_W'(SCORE_STEP);
  localparam logic [POS_W-1:0]  GX        = POS_W'(GOAL_X);
  localparam logic [POS_W-1:0]  GY        = POS_W'(GOAL_Y);

  state_t             st;
  logic [HOLD_W-1:0]  hold;
  logic               goal;

  // Requirement for the next level; the extra carry bit detects overflow.
  function automatic logic [SCORE_W-1:0] next_req(input logic [SCORE_W-1:0] s);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, s} + STEP_EXT;
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  assign goal = (hero_x_pos[POS_W-1:0]       == GX) &&
                (hero_x_pos[2*POS_W-1:POS_W] == GX) &&
                (hero_y_pos[POS_W-1:0]       == GY) &&
                (hero_y_pos[2*POS_W-1:POS_W] == GY) &&
                (score >= score_req);

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      level       <= '0;
      score_req   <= SCORE_W'(SCORE_STEP);
      time_left   <= TIME_INIT;
      hero_rst    <= 1'b0;
      level_clear <= 1'b0;
      timeout     <= 1'b0;
      game_won    <= 1'b0;
      hold        <= '0;
    end else begin
      hero_rst    <= 1'b0;
      level_clear <= 1'b0;
      timeout     <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st        <= PLAY;
            hero_rst  <= 1'b1;
            time_left <= TIME_INIT;
          end
        end
        PLAY: begin
          if (goal && (level < LVL_LAST)) begin
            st          <= CLEAR;
            level       <= level + 1'b1;
            score_req   <= next_req(score);
            level_clear <= 1'b1;
            hero_rst    <= 1'b1;
            hold        <= HOLD_INIT;
            time_left   <= TIME_INIT;
          end else if (goal) begin
            st       <= WON;
            game_won <= 1'b1;
            hero_rst <= 1'b1;
          end else if (frame_tick) begin
            // Expiry restarts the attempt at the same level.
            if (time_left > 12'd1) begin
              time_left <= time_left - 12'd1;
            end else begin
              timeout   <= 1'b1;
              hero_rst  <= 1'b1;
              time_left <= TIME_INIT;
            end
          end
        end
        CLEAR: begin
          time_left <= TIME_INIT;
          if (hold == '0) begin
            st <= PLAY;
          end else begin
            hold     <= hold - 1'b1;
            hero_rst <= 1'b1;
          end
        end
        WON: begin
          game_won <= 1'b1;
          if (start) begin
            st        <= PLAY;
            level     <= '0;
            score_req <= next_req(score);
            time_left <= TIME_INIT;
            game_won  <= 1'b0;
            hero_rst  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Parametrised level controller for the two-hero maze game.
- Watches both heroes' packed positions and the running score.
- Advances the level when both heroes stand on the goal tile with enough score, and enforces a per-level frame timer.
- Drives a multi-cycle hero reset and a terminal win state; sits between the game-logic/score units and the hero movement and drawing units.

Parameters:
LEVELS, 8, number of levels; the last index is LEVELS-1
LVL_W, 4, width of level output; must satisfy 2^LVL_W >= LEVELS
SCORE_W, 24, width of score and score_req
POS_W, 12, width of one hero coordinate; positions are packed two per bus
GOAL_X, 482, goal tile x coordinate
GOAL_Y, 108, goal tile y coordinate
SCORE_STEP, 1000, score increment required per level
CLEAR_HOLD, 16, clk cycles hero_rst is held during level transition (>=1)
TIME_FRAMES, 3600, frame ticks allowed per level attempt (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; begins or restarts the game
frame_tick  in  1  one-cycle pulse per video frame
score  in  SCORE_W  current score
hero_x_pos  in  2*POS_W  [POS_W-1:0] hero A x, [2*POS_W-1:POS_W] hero B x
hero_y_pos  in  2*POS_W  same packing for y
level  out  LVL_W  current level index
score_req  out  SCORE_W  score needed to clear current level
time_left  out  12  frames remaining in current attempt
hero_rst  out  1  hero position reset request
level_clear  out  1  one-cycle pulse on level advance
timeout  out  1  one-cycle pulse on timer expiry
game_won  out  1  high while in WON
state  out  2  IDLE=0, PLAY=1, CLEAR=2, WON=3

Behaviour:
- All outputs are registered. Each response appears on the clk edge following the cycle in which its condition holds.
- Reset values: state IDLE, level 0, score_req SCORE_STEP, time_left TIME_FRAMES, hero_rst 0, level_clear 0, timeout 0, game_won 0, hold counter 0.
- Goal condition (goal): both heroes' x == GOAL_X, both heroes' y == GOAL_Y, and score >= score_req (unsigned).
- Next score_req = score + SCORE_STEP, computed at SCORE_W+1 bits and saturated to 2^SCORE_W-1.
- IDLE:
  - start -> PLAY; hero_rst=1 for one cycle; time_left=TIME_FRAMES; level and score_req unchanged.
  - frame_tick and goal are ignored.
- PLAY:
  - goal and level < LEVELS-1 -> CLEAR; level+1; score_req updated; level_clear pulses one cycle; hero_rst=1; hold counter=CLEAR_HOLD-1.
  - goal and level == LEVELS-1 -> WON; game_won=1; level and score_req unchanged; hero_rst=1 for one cycle.
  - Otherwise, frame_tick with time_left > 1 -> time_left-1.
  - frame_tick with time_left == 1 -> timeout pulses one cycle; hero_rst pulses one cycle; time_left=TIME_FRAMES; level and score_req unchanged.
  - goal and timer expiry in the same cycle: goal has priority; no timeout pulse.
  - start is ignored.
  - hero_rst=0 on every cycle not named above.
- CLEAR:
  - hero_rst held 1; time_left held at TIME_FRAMES; goal, start and frame_tick are ignored.
  - Hold counter decrements each cycle. When it reads 0 -> PLAY and hero_rst=0.
  - Total hero_rst high time from entry is exactly CLEAR_HOLD cycles.
- WON:
  - Terminal; game_won=1; hero_rst=0 after the entry cycle.
  - start -> PLAY; level=0; score_req updated from current score; time_left=TIME_FRAMES; game_won=0; hero_rst pulses one cycle.
- Asynchronous rst at any point, including mid-CLEAR, forces all reset values immediately; a pending hold is discarded.
- level never exceeds LEVELS-1 and never wraps.

Test Plan:
- Reset then start: state 0->1; hero_rst high exactly 1 cycle; level=0; score_req=1000; time_left=3600.
- PLAY, both heroes at (482,108), score=1500: next edge level=1, score_req=2500, level_clear 1 cycle, hero_rst high exactly 16 cycles, then state=PLAY. Repeat with score=999: no change.
- Hero A at (482,108), hero B at (482,109), score=5000: no advance, level stays 0.
- Force time_left to 1 and pulse frame_tick: timeout and hero_rst 1 cycle each; time_left=3600; level unchanged. Same cycle with goal true: advance wins and timeout stays 0.
- Advance through level 7 with sufficient score: state=WON, game_won=1, level=7. Then start with score=9000: level=0, score_req=10000, state=PLAY.
- Assert rst on cycle 5 of CLEAR: all outputs at reset values on assertion, state=IDLE. score=2^24-100 on goal: score_req saturates to 16777215.
